// File: rtl/bit_pos_decoder.sv
// Expands a bit position into a one-hot or thermometer mask behind a 2-entry output buffer.
// Optional BIT_DEC_STICKY_ERR_EN adds err_clr/err_sticky for latching decode errors.
module bit_pos_decoder #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_pos,
  input  logic         in_found,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_mask,
  output logic         out_err
`ifdef BIT_DEC_STICKY_ERR_EN
  ,
  input  logic         err_clr,
  output logic         err_sticky
`endif
);

  // Entry layout: {err, mask}
  localparam int unsigned EW = N + 1;

  logic [1:0]    count_q, count_d;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] tail_q, tail_d;
  logic          in_ready_q, out_valid_q;
  logic          accept, pop;

  logic [N-1:0]  onehot;
  logic [N-1:0]  therm;
  logic          pos_oob;
  logic [EW-1:0] dec_entry;

  assign accept = in_valid && in_ready_q;
  assign pop    = out_valid_q && out_ready;

  // Decode at accept time; the thermometer is the one-hot bit plus everything below it
  always_comb begin
    onehot    = N'(1) << in_pos;
    therm     = onehot | (onehot - N'(1));
    pos_oob   = {1'b0, in_pos} >= (W+1)'(N);
    dec_entry = '0;
    if (in_found) begin
      if (pos_oob) begin
        dec_entry = {1'b1, N'(0)};
      end else begin
        dec_entry = {1'b0, in_mode ? therm : onehot};
      end
    end
  end

  // Buffer next state: head is always the oldest entry
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({accept, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = dec_entry;
        else                 tail_d = dec_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = dec_entry;
        end else begin
          head_d = tail_q;
          tail_d = dec_entry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= (count_d < 2'd2);
      out_valid_q <= (count_d != 2'd0);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_mask  = head_q[N-1:0];
  assign out_err   = head_q[N];

`ifdef BIT_DEC_STICKY_ERR_EN
  // Set on an accepted error entry; set wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (accept && dec_entry[N]) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end
`endif

endmodule
